mux_rr_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares the 4:1 data mux between four requesters.
- Grants one requester at a time and drives the mux select.
- Presents the selected data as a registered Valid/Ready stream to a single sink.
- Sits between four producer blocks and the downstream consumer. Replaces free-running select logic in the testbenches and top level.

---
 rtl/mux_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares a 4:1 data mux between four requesters and
// presents the selected data as a registered Valid/Ready stream.
module mux_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [3:0]       Req,
  input  logic [WIDTH-1:0] Input0,
  input  logic [WIDTH-1:0] Input1,
  input  logic [WIDTH-1:0] Input2,
  input  logic [WIDTH-1:0] Input3,
  input  logic             Ready,
  output logic [3:0]       Gnt,
  output logic [1:0]       Sel,
  output logic [WIDTH-1:0] Data_out,
  output logic             Valid
);

  // Counter is wide enough to hold MAX_BURST itself.
  localparam int CW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state, state_n;
  logic [1:0]      ptr, ptr_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      gnt_n;
  logic [1:0]      sel_n;
  logic [WIDTH-1:0] data_n;
  logic            valid_n;

  logic [WIDTH-1:0] in_arr [4];
  logic             idle_found;
  logic [1:0]       idle_win;
  logic             rel_found;
  logic [1:0]       rel_win;
  logic [1:0]       rel_ptr;
  logic             last_beat;

  // First requester found scanning cyclically upward from the pointer;
  // bit 2 of the result flags whether anyone is requesting at all.
  function automatic logic [2:0] arbitrate(input logic [3:0] req, input logic [1:0] from);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 0; k < 4; k++) begin
      idx = from + 2'(k);
      if (!res[2] && req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  assign in_arr[0] = Input0;
  assign in_arr[1] = Input1;
  assign in_arr[2] = Input2;
  assign in_arr[3] = Input3;

  // Both arbitration candidates are evaluated every cycle: one from the
  // current pointer (used when idle) and one from the rotated pointer
  // (used when the current grant releases on a transfer).
  assign rel_ptr = Sel + 2'd1;
  always_comb begin
    {idle_found, idle_win} = arbitrate(Req, ptr);
    {rel_found, rel_win}   = arbitrate(Req, rel_ptr);
  end

  // A transfer ends the grant when the owner stops asking or the burst is full.
  assign last_beat = !Req[Sel] || ((int'(cnt) + 1) >= MAX_BURST);

  // Next-state and next-output decode; the outputs are all registered so the
  // sink sees a clean, glitch-free stream.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_n   = Gnt;
    sel_n   = Sel;
    data_n  = Data_out;
    valid_n = Valid;
    case (state)
      IDLE: begin
        if (idle_found) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << idle_win;
          sel_n   = idle_win;
          data_n  = in_arr[idle_win];
          valid_n = 1'b1;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (Ready) begin
          if (!last_beat) begin
            cnt_n  = cnt + CW'(1);
            data_n = in_arr[Sel];
          end else begin
            ptr_n = rel_ptr;
            cnt_n = '0;
            if (rel_found) begin
              gnt_n   = 4'b0001 << rel_win;
              sel_n   = rel_win;
              data_n  = in_arr[rel_win];
              valid_n = 1'b1;
            end else begin
              state_n = IDLE;
              gnt_n   = 4'b0000;
              valid_n = 1'b0;
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        valid_n = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight beat at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      cnt      <= '0;
      Gnt      <= 4'b0000;
      Sel      <= 2'd0;
      Data_out <= '0;
      Valid    <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      cnt      <= cnt_n;
      Gnt      <= gnt_n;
      Sel      <= sel_n;
      Data_out <= data_n;
      Valid    <= valid_n;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: a behavioural model predicts each
// cycle's outputs into a queue that an independent monitor drains and checks.
module tb_mux_rr_arbiter;

  localparam int WIDTH     = 4;
  localparam int MAX_BURST = 4;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [3:0]       Req;
  logic [WIDTH-1:0] Input0, Input1, Input2, Input3;
  logic             Ready;
  logic [3:0]       Gnt;
  logic [1:0]       Sel;
  logic [WIDTH-1:0] Data_out;
  logic             Valid;

  typedef struct packed {
    logic             valid;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model state: who owns the mux and how many beats it has sent.
  bit               m_busy;
  int               m_owner;
  int               m_beats;
  int               m_ptr;
  int               m_sel;
  logic [WIDTH-1:0] m_data;

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req),
    .Input0(Input0), .Input1(Input1), .Input2(Input2), .Input3(Input3),
    .Ready(Ready), .Gnt(Gnt), .Sel(Sel), .Data_out(Data_out), .Valid(Valid)
  );

  always #5 Clk = ~Clk;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic modelReset();
    m_busy  = 0;
    m_owner = 0;
    m_beats = 0;
    m_ptr   = 0;
    m_sel   = 0;
    m_data  = '0;
  endtask

  function automatic int pick(input logic [3:0] r, input int from);
    for (int k = 0; k < 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic modelGrant(input int w, input logic [WIDTH-1:0] inp [4]);
    m_busy  = 1;
    m_owner = w;
    m_sel   = w;
    m_beats = 0;
    m_data  = inp[w];
  endtask

  task automatic modelStep(input logic [3:0] r, input logic [WIDTH-1:0] inp [4], input logic rdy);
    int w;
    if (!m_busy) begin
      w = pick(r, m_ptr);
      if (w >= 0) modelGrant(w, inp);
    end else if (rdy) begin
      m_beats++;
      if (r[m_owner] && m_beats < MAX_BURST) begin
        m_data = inp[m_owner];
      end else begin
        m_ptr = (m_owner + 1) % 4;
        w = pick(r, m_ptr);
        if (w >= 0) modelGrant(w, inp);
        else m_busy = 0;
      end
    end
  endtask

  function automatic exp_t modelOut();
    exp_t e;
    e.valid = m_busy;
    e.gnt   = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    e.sel   = 2'(m_sel);
    e.data  = m_data;
    return e;
  endfunction

  // Drives one cycle of stimulus and records the outputs expected after the edge.
  task automatic applyStimulus(input logic [3:0] r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d, input logic rdy);
    logic [WIDTH-1:0] inp [4];
    @(negedge Clk);
    Req = r; Input0 = a; Input1 = b; Input2 = c; Input3 = d; Ready = rdy;
    inp[0] = a; inp[1] = b; inp[2] = c; inp[3] = d;
    modelStep(r, inp, rdy);
    exp_q.push_back(modelOut());
  endtask

  task automatic checkOutput(input exp_t e);
    checkValue("valid", 32'(Valid), 32'(e.valid));
    checkValue("gnt", 32'(Gnt), 32'(e.gnt));
    checkValue("sel", 32'(Sel), 32'(e.sel));
    checkValue("data_out", 32'(Data_out), 32'(e.data));
  endtask

  // Monitor: compares the DUT against the oldest prediction shortly after each edge.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput(e);
    end
  end

  // Watchdog so the run always reaches its summary.
  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [3:0] r;
    Reset = 1'b1; Req = '0; Ready = 1'b0;
    Input0 = '0; Input1 = '0; Input2 = '0; Input3 = '0;
    modelReset();
    #1;
    checkValue("reset_valid", 32'(Valid), 0);
    checkValue("reset_gnt", 32'(Gnt), 0);
    checkValue("reset_sel", 32'(Sel), 0);
    checkValue("reset_data", 32'(Data_out), 0);
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b0;

    // Single requester: repeated bursts on requester 0.
    applyStimulus(4'b0001, 4'd5, 4'd0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 9; i++)
      applyStimulus(4'b0001, WIDTH'(i + 6), 4'd0, 4'd0, 4'd0, 1'b1);
    applyStimulus(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    applyStimulus(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);

    // Full contention with each input carrying its own index.
    for (int i = 0; i < 20; i++)
      applyStimulus(4'b1111, 4'd0, 4'd1, 4'd2, 4'd3, 1'b1);
    applyStimulus(4'b0000, 4'd0, 4'd1, 4'd2, 4'd3, 1'b1);
    applyStimulus(4'b0000, 4'd0, 4'd1, 4'd2, 4'd3, 1'b1);

    // Backpressure and data tracking on requester 1.
    applyStimulus(4'b0010, 4'd0, 4'd3, 4'd0, 4'd0, 1'b1);
    applyStimulus(4'b0010, 4'd0, 4'd3, 4'd0, 4'd0, 1'b0);
    applyStimulus(4'b0010, 4'd0, 4'd9, 4'd0, 4'd0, 1'b0);
    applyStimulus(4'b0010, 4'd0, 4'd9, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(4'b0010, 4'd0, 4'd9, 4'd0, 4'd0, 1'b1);
    applyStimulus(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    applyStimulus(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);

    // Early drop: requester 0 leaves mid-burst, requester 2 takes over.
    applyStimulus(4'b0101, 4'd1, 4'd0, 4'd7, 4'd0, 1'b1);
    applyStimulus(4'b0101, 4'd2, 4'd0, 4'd7, 4'd0, 1'b1);
    applyStimulus(4'b0100, 4'd3, 4'd0, 4'd7, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++)
      applyStimulus(4'b0100, 4'd3, 4'd0, WIDTH'(i), 4'd0, 1'b1);

    // Randomized traffic with sticky requests and random backpressure.
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      applyStimulus(r, WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                    ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset mid-burst, between clock edges.
    applyStimulus(4'b1111, 4'd4, 4'd5, 4'd6, 4'd7, 1'b1);
    applyStimulus(4'b1111, 4'd4, 4'd5, 4'd6, 4'd7, 1'b1);
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    Req   = 4'b0000;
    #1;
    checkValue("async_valid", 32'(Valid), 0);
    checkValue("async_gnt", 32'(Gnt), 0);
    checkValue("async_data", 32'(Data_out), 0);
    checkValue("async_sel", 32'(Sel), 0);
    exp_q.delete();
    modelReset();
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 6; i++)
      applyStimulus(4'b1010, 4'd0, 4'd11, 4'd0, 4'd13, 1'b1);
    for (int i = 0; i < 60; i++)
      applyStimulus(4'($urandom_range(0, 15)), WIDTH'($urandom), WIDTH'($urandom),
                    WIDTH'($urandom), WIDTH'($urandom), ($urandom_range(0, 1) != 0));

    repeat (3) @(negedge Clk);
    checkValue("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
